// File: rtl/mgmt_spi_master.sv
// Byte-oriented SPI master (mode 0, MSB first) behind a 4-word register port.
// Latency: register access acknowledged one cycle after the strobe; a byte takes 16 SCK half-periods plus CS setup/hold.
// Backpressure: none; a TXDATA write while busy or disabled is dropped, so firmware polls STATUS.busy.
//
// Ports:
//   core_clk, core_rstn               clock, asynchronous active-low reset
//   reg_addr/wdata/we/re              register access (0=CTRL 1=STATUS 2=TXDATA 3=RXDATA)
//   reg_rdata/reg_ready               read data and one-cycle acknowledge
//   spi_sck/csb/sdo/sdoenb, spi_sdi   SPI pins
//   irq                               rx_valid gated by CTRL.irq_en
// Optional feature: define SPI_MASTER_LOOPBACK_EN to make CTRL[3] an internal sdo->sdi loopback.
module mgmt_spi_master #(
    parameter int CLKDIV_W     = 8,
    parameter int CLKDIV_RESET = 2
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_we,
    input  logic        reg_re,
    output logic [31:0] reg_rdata,
    output logic        reg_ready,
    output logic        spi_sck,
    output logic        spi_csb,
    output logic        spi_sdo,
    input  logic        spi_sdi,
    output logic        spi_sdoenb,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                r_enable;
    logic                r_cs_hold;
    logic                r_irq_en;
    logic [CLKDIV_W-1:0] r_div;
    logic [CLKDIV_W-1:0] r_div_lat;   // divider frozen for the transfer in flight
    logic [CLKDIV_W-1:0] r_cnt;
    logic [3:0]          r_half;      // half-period index within SHIFT
    logic [7:0]          r_tx;
    logic [7:0]          r_rx;
    logic [7:0]          r_rx_byte;
    logic                r_rx_valid;
    logic                r_sck;
    logic                r_csb;
    logic                r_ready;
    logic [31:0]         r_rdata;

    logic                w_ctrl_wr;
    logic                w_tx_wr;
    logic                w_rx_rd;
    logic                w_en_nxt;
    logic                w_hold_nxt;
    logic                w_tick;
    logic                w_start;
    logic                w_abort;
    logic                w_done;
    logic                w_shift_tick;
    logic                w_rise;
    logic                w_fall;
    logic                w_sdi;
    logic                w_loopback;
    logic [31:0]         w_rd_mux;
    logic                w_unused;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic r_loopback;
    assign w_loopback = r_loopback;
    // Loopback samples the shifter's own MSB, which is exactly what is on spi_sdo.
    assign w_sdi      = r_loopback ? r_tx[7] : spi_sdi;
`else
    assign w_loopback = 1'b0;
    assign w_sdi      = spi_sdi;
`endif

    assign w_unused = ^reg_wdata[31:8+CLKDIV_W];

    assign w_ctrl_wr    = reg_we && (reg_addr == 2'd0);
    assign w_tx_wr      = reg_we && (reg_addr == 2'd2);
    assign w_rx_rd      = reg_re && (reg_addr == 2'd3);
    // Post-write values of enable/cs_hold let csb and abort react in the cycle after the CTRL write.
    assign w_en_nxt     = w_ctrl_wr ? reg_wdata[0] : r_enable;
    assign w_hold_nxt   = w_ctrl_wr ? reg_wdata[1] : r_cs_hold;
    assign w_tick       = (r_cnt == '0);
    assign w_start      = (r_state == ST_IDLE) && w_tx_wr && r_enable;
    assign w_abort      = (r_state != ST_IDLE) && !w_en_nxt;
    assign w_shift_tick = (r_state == ST_SHIFT) && w_tick;
    assign w_rise       = w_shift_tick && !r_half[0];
    assign w_fall       = w_shift_tick && r_half[0];

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // With cs_hold keeping csb low, the setup half-period is skipped.
                if (w_start) begin
                    w_state_nxt = r_csb ? ST_CS_SETUP : ST_SHIFT;
                end
            end
            ST_CS_SETUP: begin
                if (w_tick) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_tick && (r_half == 4'd15)) begin
                    if (r_cs_hold) begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end else begin
                        w_state_nxt = ST_CS_HOLD;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_done      = 1'b0;
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (reg_addr)
            2'd0: begin
                w_rd_mux[0]               = r_enable;
                w_rd_mux[1]               = r_cs_hold;
                w_rd_mux[2]               = r_irq_en;
                w_rd_mux[3]               = w_loopback;
                w_rd_mux[8 +: CLKDIV_W]   = r_div;
            end
            2'd1: begin
                w_rd_mux[0] = (r_state != ST_IDLE);
                w_rd_mux[1] = r_rx_valid;
            end
            2'd3: begin
                w_rd_mux[7:0] = r_rx_byte;
            end
            default: begin
                w_rd_mux = '0;
            end
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            r_enable   <= 1'b0;
            r_cs_hold  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_div      <= CLKDIV_W'(CLKDIV_RESET);
            r_div_lat  <= CLKDIV_W'(CLKDIV_RESET);
            r_cnt      <= '0;
            r_half     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
            r_sck      <= 1'b0;
            r_csb      <= 1'b1;
            r_ready    <= 1'b0;
            r_rdata    <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
            r_loopback <= 1'b0;
`endif
        end else begin
            if (w_ctrl_wr) begin
                r_enable  <= reg_wdata[0];
                r_cs_hold <= reg_wdata[1];
                r_irq_en  <= reg_wdata[2];
                r_div     <= reg_wdata[8 +: CLKDIV_W];
`ifdef SPI_MASTER_LOOPBACK_EN
                r_loopback <= reg_wdata[3];
`endif
            end

            // Half-period timer: runs only while a transfer is in flight.
            if (w_start) begin
                r_div_lat <= r_div;
                r_cnt     <= r_div;
                r_half    <= '0;
            end else if (r_state != ST_IDLE) begin
                r_cnt <= w_tick ? r_div_lat : r_cnt - 1'b1;
                if (w_shift_tick) begin
                    r_half <= r_half + 1'b1;
                end
            end

            // Loading the byte puts bit7 on spi_sdo ahead of the first rising edge.
            if (w_start) begin
                r_tx <= reg_wdata[7:0];
            end else if (w_fall) begin
                r_tx <= {r_tx[6:0], 1'b0};
            end

            if (w_rise) begin
                r_rx <= {r_rx[6:0], w_sdi};
            end

            if (w_abort) begin
                r_sck <= 1'b0;
            end else if (w_shift_tick) begin
                r_sck <= ~r_sck;
            end

            if (w_abort) begin
                r_csb <= 1'b1;
            end else if (w_start) begin
                r_csb <= 1'b0;
            end else if ((r_state == ST_CS_HOLD) && w_tick) begin
                r_csb <= 1'b1;
            end else if ((r_state == ST_IDLE) && (!w_en_nxt || !w_hold_nxt)) begin
                r_csb <= 1'b1;
            end

            // Completion wins over a same-cycle RXDATA read; the read still sees the old byte.
            if (w_done) begin
                r_rx_byte  <= r_rx;
                r_rx_valid <= 1'b1;
            end else if (w_rx_rd) begin
                r_rx_valid <= 1'b0;
            end

            r_ready <= reg_we || reg_re;
            r_rdata <= reg_re ? w_rd_mux : 32'd0;
        end
    end

    assign reg_rdata  = r_rdata;
    assign reg_ready  = r_ready;
    assign spi_sck    = r_sck;
    assign spi_csb    = r_csb;
    assign spi_sdo    = r_tx[7];
    assign spi_sdoenb = r_csb;
    assign irq        = r_rx_valid && r_irq_en;

endmodule

// File: tb/tb_mgmt_spi_master.sv
// Directed bench for mgmt_spi_master with a byte-level SPI slave model.
// Latency: register accesses take one cycle; transfers are polled through STATUS.busy.
// Backpressure: none; waits on the DUT are bounded by cycle budgets.
module tb_mgmt_spi_master;

    logic        core_clk  = 1'b0;
    logic        core_rstn = 1'b0;
    logic [1:0]  reg_addr  = 2'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic        reg_we    = 1'b0;
    logic        reg_re    = 1'b0;
    logic [31:0] reg_rdata;
    logic        reg_ready;
    logic        spi_sck;
    logic        spi_csb;
    logic        spi_sdo;
    logic        spi_sdi;
    logic        spi_sdoenb;
    logic        irq;

    mgmt_spi_master dut (
        .core_clk   (core_clk),
        .core_rstn  (core_rstn),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .reg_ready  (reg_ready),
        .spi_sck    (spi_sck),
        .spi_csb    (spi_csb),
        .spi_sdo    (spi_sdo),
        .spi_sdi    (spi_sdi),
        .spi_sdoenb (spi_sdoenb),
        .irq        (irq)
    );

    always #5 core_clk = ~core_clk;

    int n_vec = 0;
    int n_err = 0;

    // Slave model: returns s_byte MSB first, advancing one bit per falling SCK edge
    // counted from s_base; captures MOSI on every rising edge.
    int              s_rise = 0;
    int              s_fall = 0;
    int              s_base = 0;
    int              s_idx;
    int              s_csb_hi = 0;
    int              s_csb_rises = 0;
    logic [7:0]      s_byte = 8'h00;
    logic [7:0]      s_mosi = 8'h00;
    logic            s_force0 = 1'b0;
    longint unsigned rise_t [1024];
    longint unsigned fall_t [1024];

    always @(posedge spi_sck) begin
        s_mosi = {s_mosi[6:0], spi_sdo};
        rise_t[s_rise % 1024] = $time;
        s_rise++;
    end

    always @(negedge spi_sck) begin
        fall_t[s_fall % 1024] = $time;
        s_fall++;
    end

    always @(posedge spi_csb) s_csb_rises++;
    always @(posedge core_clk) if (spi_csb) s_csb_hi++;

    always_comb begin
        s_idx = s_fall - s_base;
        if (s_force0 || s_idx < 0 || s_idx > 7) spi_sdi = 1'b0;
        else                                     spi_sdi = s_byte[7 - s_idx];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        @(posedge core_clk); #1;
        reg_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        reg_addr = a;
        reg_re   = 1'b1;
        @(posedge core_clk); #1;
        reg_re   = 1'b0;
        d        = reg_rdata;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] st;
        int          n;
        st = 32'd1;
        n  = 0;
        while (st[0] && n < 3000) begin
            rd(2'd1, st);
            n++;
        end
        check(tag, {31'd0, st[0]}, 32'd0);
    endtask

    // One byte: slave answers slv, master sends tx; checks MOSI and SCK pulse count.
    task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] slv);
        int r0;
        s_byte = slv;
        s_base = s_fall;
        r0     = s_rise;
        wr(2'd2, {24'd0, tx});
        wait_idle({tag, "_idle"});
        check({tag, "_mosi"}, {24'd0, s_mosi}, {24'd0, tx});
        check({tag, "_pulses"}, s_rise - r0, 32'd8);
    endtask

    logic [31:0] v;
    logic [7:0]  flash [11] = '{8'h93, 8'h01, 8'h00, 8'h13, 8'h02, 8'h63,
                                8'h57, 8'hb5, 8'h00, 8'h23, 8'h20};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r0;
        int f0;
        int n;
        int hi0;
        int cr0;

        // Reset state
        core_rstn = 1'b0;
        repeat (3) @(posedge core_clk);
        #1;
        check("rst_sck", {31'd0, spi_sck}, 32'd0);
        check("rst_csb", {31'd0, spi_csb}, 32'd1);
        check("rst_sdoenb", {31'd0, spi_sdoenb}, 32'd1);
        check("rst_sdo", {31'd0, spi_sdo}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ready", {31'd0, reg_ready}, 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        core_rstn = 1'b1;
        @(posedge core_clk); #1;
        rd(2'd1, v);
        check("rst_status", v, 32'd0);
        check("rd_ready", {31'd0, reg_ready}, 32'd1);
        rd(2'd0, v);
        check("rst_ctrl", v, 32'h0000_0200);

        // TXDATA ignored while disabled
        wr(2'd2, 32'h11);
        rd(2'd1, v);
        check("dis_tx_status", v, 32'd0);
        check("dis_tx_csb", {31'd0, spi_csb}, 32'd1);

        // CTRL readback
        wr(2'd0, 32'h0000_020F);
        rd(2'd0, v);
`ifdef SPI_MASTER_LOOPBACK_EN
        check("ctrl_rb", v, 32'h0000_020F);
`else
        check("ctrl_rb", v, 32'h0000_0207);
`endif

        // Basic byte: TX A5, slave 3C, div=2
        wr(2'd0, 32'h0000_0201);
        s_byte = 8'h3C;
        s_base = s_fall;
        r0     = s_rise;
        f0     = s_fall;
        wr(2'd2, 32'hA5);
        check("b_csb_low", {31'd0, spi_csb}, 32'd0);
        check("b_sdoenb_low", {31'd0, spi_sdoenb}, 32'd0);
        check("b_sdo_msb", {31'd0, spi_sdo}, 32'd1);
        rd(2'd1, v);
        check("b_busy", v, 32'd1);
        wait_idle("b_idle");
        check("b_pulses", s_rise - r0, 32'd8);
        check("b_mosi", {24'd0, s_mosi}, 32'hA5);
        for (int i = 0; i < 7; i++)
            check("b_sck_period", 32'(rise_t[(r0 + i + 1) % 1024] - rise_t[(r0 + i) % 1024]), 32'd60);
        for (int i = 0; i < 8; i++)
            check("b_sck_high", 32'(fall_t[(f0 + i) % 1024] - rise_t[(r0 + i) % 1024]), 32'd30);
        check("b_sck_idle", {31'd0, spi_sck}, 32'd0);
        check("b_csb_high", {31'd0, spi_csb}, 32'd1);
        rd(2'd1, v);
        check("b_rxv", v, 32'd2);
        check("b_irq_off", {31'd0, irq}, 32'd0);
        rd(2'd3, v);
        check("b_rxdata", v, 32'h3C);
        rd(2'd1, v);
        check("b_rxv_clr", v, 32'd0);

        // Flash read with cs_hold=1
        wr(2'd0, 32'h0000_0203);
        xfer("f_cmd", 8'h03, 8'hFF);
        hi0 = s_csb_hi;
        xfer("f_a2", 8'h00, 8'hFF);
        xfer("f_a1", 8'h00, 8'hFF);
        xfer("f_a0", 8'h00, 8'hEE);
        rd(2'd3, v);
        check("f_overwrite", v, 32'hEE);
        for (int i = 0; i < 11; i++) begin
            xfer("f_dummy", 8'h00, flash[i]);
            rd(2'd3, v);
            check("f_rxdata", v, {24'd0, flash[i]});
            check("f_csb_low", {31'd0, spi_csb}, 32'd0);
        end
        check("f_csb_never_high", s_csb_hi - hi0, 32'd0);
        wr(2'd0, 32'h0000_0201);
        check("f_csb_release", {31'd0, spi_csb}, 32'd1);

        // cs_hold=0 back-to-back, write while busy ignored
        cr0    = s_csb_rises;
        s_byte = 8'h42;
        s_base = s_fall;
        r0     = s_rise;
        wr(2'd2, 32'h81);
        wr(2'd2, 32'h7E);
        wait_idle("bb1_idle");
        check("bb1_mosi", {24'd0, s_mosi}, 32'h81);
        check("bb1_pulses", s_rise - r0, 32'd8);
        check("bb1_csb_high", {31'd0, spi_csb}, 32'd1);
        rd(2'd3, v);
        check("bb1_rxdata", v, 32'h42);
        xfer("bb2", 8'h24, 8'h18);
        check("bb_csb_rises", s_csb_rises - cr0, 32'd2);
        rd(2'd1, v);
        check("bb2_rxv", v, 32'd2);

        // Abort at bit 4
        s_byte = 8'hFF;
        s_base = s_fall;
        r0     = s_rise;
        wr(2'd2, 32'hF0);
        n = 0;
        while ((s_rise - r0) < 4 && n < 500) begin
            @(posedge core_clk); #1;
            n++;
        end
        check("ab_reach", s_rise - r0, 32'd4);
        wr(2'd0, 32'h0000_0200);
        check("ab_csb", {31'd0, spi_csb}, 32'd1);
        check("ab_sck", {31'd0, spi_sck}, 32'd0);
        rd(2'd1, v);
        check("ab_status", v, 32'd2);
        check("ab_no_more_sck", s_rise - r0, 32'd4);
        wr(2'd0, 32'h0000_0201);
        xfer("ab_after", 8'h3C, 8'hC3);
        wr(2'd0, 32'h0000_0205);
        check("irq_on", {31'd0, irq}, 32'd1);
        rd(2'd3, v);
        check("ab_rxdata", v, 32'hC3);
        check("irq_off", {31'd0, irq}, 32'd0);

        // div=0 and RXDATA read coinciding with completion
        wr(2'd0, 32'h0000_0005);
        s_byte = 8'h99;
        s_base = s_fall;
        r0     = s_rise;
        wr(2'd2, 32'h66);
        repeat (17) @(posedge core_clk);
        #1;
        rd(2'd3, v);
        check("race_old_byte", v, 32'hC3);
        rd(2'd1, v);
        check("race_rxv", v, 32'd2);
        check("race_irq", {31'd0, irq}, 32'd1);
        rd(2'd3, v);
        check("race_new_byte", v, 32'h99);
        check("d0_period", 32'(rise_t[(r0 + 1) % 1024] - rise_t[r0 % 1024]), 32'd20);
        check("d0_pulses", s_rise - r0, 32'd8);
        check("d0_mosi", {24'd0, s_mosi}, 32'h66);

`ifdef SPI_MASTER_LOOPBACK_EN
        // Loopback with spi_sdi held low
        wr(2'd0, 32'h0000_020D);
        s_force0 = 1'b1;
        xfer("lb", 8'h5A, 8'h00);
        check("lb_irq", {31'd0, irq}, 32'd1);
        rd(2'd3, v);
        check("lb_rxdata", v, 32'h5A);
        s_force0 = 1'b0;
`endif

        // Reset mid-transfer
        wr(2'd0, 32'h0000_0201);
        s_byte = 8'h00;
        s_base = s_fall;
        wr(2'd2, 32'hFF);
        repeat (10) @(posedge core_clk);
        #1;
        core_rstn = 1'b0;
        #1;
        check("mr_csb", {31'd0, spi_csb}, 32'd1);
        check("mr_sck", {31'd0, spi_sck}, 32'd0);
        @(posedge core_clk); #1;
        core_rstn = 1'b1;
        @(posedge core_clk); #1;
        rd(2'd1, v);
        check("mr_status", v, 32'd0);
        rd(2'd0, v);
        check("mr_ctrl", v, 32'h0000_0200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
